// File: rtl/fpdiv_sig_divider_if.sv
// Start/finish valid-ready bundle between an FP divide front end and its significand divider.
// The front end drives the master side and the divider sits on the slave side.
interface fpdiv_sig_divider_if;
  logic        start_valid_i;
  logic        start_ready_o;
  logic        flush_i;
  logic [1:0]  fp_format_i;
  logic [52:0] siga_i;
  logic [52:0] sigb_i;
  logic        finish_valid_o;
  logic        finish_ready_i;
  logic [54:0] quo_o;
  logic        sticky_o;

  modport master (
    output start_valid_i, flush_i, fp_format_i, siga_i, sigb_i, finish_ready_i,
    input  start_ready_o, finish_valid_o, quo_o, sticky_o
  );

  modport slave (
    input  start_valid_i, flush_i, fp_format_i, siga_i, sigb_i, finish_ready_i,
    output start_ready_o, finish_valid_o, quo_o, sticky_o
  );
endinterface

// File: rtl/fpdiv_sig_divider.sv
// Radix-2 restoring divider for normalized FP16/FP32/FP64 significands.
// Produces a left-aligned quotient plus sticky bit through a finish handshake.
module fpdiv_sig_divider (
  input  logic               clk,
  input  logic               rst,
  fpdiv_sig_divider_if.slave div_if
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  fmt_q, fmt_d;
  logic [52:0] sigb_q, sigb_d;
  logic [53:0] rem_q, rem_d;
  logic [53:0] quo_q, quo_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [54:0] res_q, res_d;
  logic        sticky_q, sticky_d;

  logic        qbit;
  logic [52:0] remSub;
  logic [53:0] remStep;
  logic [54:0] quoStep;
  logic [54:0] quoAligned;
  logic        startFire;

  // Iterations minus one: fraction width plus two (integer, extra and guard bits).
  function automatic logic [5:0] lastIter(input logic [1:0] fmt);
    case (fmt)
      2'd0:    lastIter = 6'd12;
      2'd1:    lastIter = 6'd25;
      default: lastIter = 6'd54;
    endcase
  endfunction

  // With a normalized divisor the remainder stays below 2*sigb, so the
  // difference always fits in 53 bits.
  assign qbit    = rem_q >= {1'b0, sigb_q};
  assign remSub  = rem_q[52:0] - sigb_q;
  assign remStep = qbit ? {remSub, 1'b0} : {rem_q[52:0], 1'b0};
  assign quoStep = {quo_q, qbit};

  always_comb begin
    case (fmt_q)
      2'd0:    quoAligned = quoStep << 42;
      2'd1:    quoAligned = quoStep << 29;
      default: quoAligned = quoStep;
    endcase
  end

  assign div_if.start_ready_o  = (state_q == IDLE) && !div_if.flush_i;
  assign div_if.finish_valid_o = (state_q == DONE);
  assign div_if.quo_o          = res_q;
  assign div_if.sticky_o       = sticky_q;
  assign startFire             = div_if.start_valid_i && div_if.start_ready_o;

  // Next-state and datapath updates; flush overrides every handshake.
  always_comb begin
    state_d  = state_q;
    fmt_d    = fmt_q;
    sigb_d   = sigb_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    sticky_d = sticky_q;

    case (state_q)
      IDLE: begin
        if (startFire) begin
          fmt_d   = div_if.fp_format_i;
          sigb_d  = div_if.sigb_i;
          rem_d   = {1'b0, div_if.siga_i};
          quo_d   = '0;
          cnt_d   = lastIter(div_if.fp_format_i);
          state_d = ITER;
        end
      end
      ITER: begin
        rem_d = remStep;
        quo_d = quoStep[53:0];
        if (cnt_q == 6'd0) begin
          res_d    = quoAligned;
          sticky_d = |remStep;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      DONE: begin
        if (div_if.finish_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (div_if.flush_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      fmt_q    <= '0;
      sigb_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fmt_q    <= fmt_d;
      sigb_q   <= sigb_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      sticky_q <= sticky_d;
    end
  end

endmodule

// File: tb/tb_fpdiv_sig_divider.sv
// Bench for fpdiv_sig_divider: a cycle-level reference of the handshake timing plus an
// exact integer division model, compared against the outputs on every falling edge.
module tb_fpdiv_sig_divider;

  localparam logic [52:0] ONE      = 53'h10000000000000;
  localparam logic [52:0] ONE_HALF = 53'h18000000000000;

  logic clk;
  logic rst;
  fpdiv_sig_divider_if divIf();

  fpdiv_sig_divider dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (divIf)
  );

  int          errors = 0;
  int          checks = 0;
  int          cycle = 0;
  bit          mBusy = 1'b0;
  int          mDoneCycle = 0;
  logic [54:0] mQuo = '0;
  logic        mSticky = 1'b0;
  bit          mNorm = 1'b0;
  bit          cmpValid;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int nIter(input logic [1:0] fmt);
    case (fmt)
      2'd0:    return 13;
      2'd1:    return 26;
      default: return 55;
    endcase
  endfunction

  // Quotient floor(A*2^(N-1)/B) left-aligned in 55 bits; sticky is a non-zero remainder.
  task automatic modelDivide(input logic [1:0] fmt, input logic [52:0] a, input logic [52:0] b,
                             output logic [54:0] q, output logic s);
    int n;
    logic [127:0] num, den, qq, rr;
    n   = nIter(fmt);
    num = 128'(a) << (n - 1);
    den = 128'(b);
    if (den == 128'd0) begin
      q = '0;
      s = 1'b0;
    end else begin
      qq = num / den;
      rr = num % den;
      q  = qq[54:0] << (55 - n);
      s  = (rr != 128'd0);
    end
  endtask

  function automatic logic [52:0] randSig(input logic [1:0] fmt);
    logic [63:0] r;
    logic [52:0] v;
    int f;
    r = {$urandom(), $urandom()};
    v = {1'b1, r[51:0]};
    f = (fmt == 2'd0) ? 10 : (fmt == 2'd1) ? 23 : 52;
    for (int i = 0; i < 52 - f; i++) v[i] = 1'b0;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [54:0] act, input logic [54:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference state: busy from an accepted start until the finish handshake,
  // result valid from N+1 cycles after the start cycle.
  always @(posedge clk) begin
    if (rst || divIf.flush_i) begin
      mBusy = 1'b0;
    end else if (!mBusy) begin
      if (divIf.start_valid_i) begin
        mBusy      = 1'b1;
        mDoneCycle = cycle + nIter(divIf.fp_format_i) + 1;
        mNorm      = divIf.sigb_i[52];
        modelDivide(divIf.fp_format_i, divIf.siga_i, divIf.sigb_i, mQuo, mSticky);
      end
    end else if (cycle >= mDoneCycle && divIf.finish_ready_i) begin
      mBusy = 1'b0;
    end
    cycle++;
  end

  always @(negedge clk) begin
    if (!rst) begin
      cmpValid = mBusy && (cycle >= mDoneCycle);
      checkOutput("finish_valid", 55'(divIf.finish_valid_o), 55'(cmpValid));
      checkOutput("start_ready", 55'(divIf.start_ready_o), 55'(!mBusy && !divIf.flush_i));
      if (cmpValid && mNorm) begin
        checkOutput("quo", divIf.quo_o, mQuo);
        checkOutput("sticky", 55'(divIf.sticky_o), 55'(mSticky));
      end
    end
  end

  // Entered and left at #1 after a rising edge; returns in the first cycle after the start handshake.
  task automatic startOp(input logic [1:0] fmt, input logic [52:0] a, input logic [52:0] b,
                         input int sDelay);
    int guard;
    bit hs;
    guard = 0;
    hs    = 1'b0;
    repeat (sDelay) begin @(posedge clk); #1; end
    divIf.fp_format_i   = fmt;
    divIf.siga_i        = a;
    divIf.sigb_i        = b;
    divIf.start_valid_i = 1'b1;
    while (!hs && guard < 300) begin
      @(negedge clk);
      hs = divIf.start_ready_o;
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("start_handshake", 55'(hs), 55'd1);
    divIf.start_valid_i = 1'b0;
    divIf.fp_format_i   = 2'($urandom());
    divIf.siga_i        = randSig(2'd2);
    divIf.sigb_i        = randSig(2'd2);
  endtask

  task automatic waitFinish(input int rDelay, output logic [54:0] q, output logic s, output int lat);
    bit done;
    done = 1'b0;
    lat  = 1;
    divIf.finish_ready_i = (rDelay == 0);
    while (lat < 300) begin
      @(negedge clk);
      if (divIf.finish_valid_o) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("finish_seen", 55'(done), 55'd1);
    q = divIf.quo_o;
    s = divIf.sticky_o;
    repeat (rDelay) begin @(posedge clk); #1; end
    divIf.finish_ready_i = 1'b1;
    @(posedge clk); #1;
    divIf.finish_ready_i = 1'b0;
  endtask

  task automatic applyStimulus(input logic [1:0] fmt, input logic [52:0] a, input logic [52:0] b,
                               input int sDelay, input int rDelay,
                               output logic [54:0] q, output logic s, output int lat);
    startOp(fmt, a, b, sDelay);
    waitFinish(rDelay, q, s, lat);
  endtask

  initial begin
    logic [54:0] q, mq;
    logic        s, ms;
    int          lat;
    logic [1:0]  fmt;
    logic [52:0] a, b;

    rst                  = 1'b1;
    divIf.start_valid_i  = 1'b0;
    divIf.flush_i        = 1'b0;
    divIf.fp_format_i    = 2'd0;
    divIf.siga_i         = '0;
    divIf.sigb_i         = '0;
    divIf.finish_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_valid", 55'(divIf.finish_valid_o), 55'd0);
    checkOutput("reset_quo", divIf.quo_o, 55'd0);
    checkOutput("reset_sticky", 55'(divIf.sticky_o), 55'd0);
    checkOutput("reset_ready", 55'(divIf.start_ready_o), 55'd1);
    @(posedge clk); #1;

    // Hand-computed results pin both the model and the design.
    modelDivide(2'd2, ONE, ONE, mq, ms);
    checkOutput("model_fp64_quo", mq, 55'h40000000000000);
    modelDivide(2'd0, ONE, ONE_HALF, mq, ms);
    checkOutput("model_fp16_quo", mq, 55'h2AA80000000000);
    checkOutput("model_fp16_sticky", 55'(ms), 55'd1);

    applyStimulus(2'd2, ONE, ONE, 0, 0, q, s, lat);
    checkOutput("fp64_latency", 55'(lat), 55'd56);
    checkOutput("fp64_quo", q, 55'h40000000000000);
    checkOutput("fp64_sticky", 55'(s), 55'd0);

    applyStimulus(2'd1, ONE_HALF, ONE, 0, 0, q, s, lat);
    checkOutput("fp32_latency", 55'(lat), 55'd27);
    checkOutput("fp32_quo", q, 55'h60000000000000);
    checkOutput("fp32_low_zero", 55'(q[28:0]), 55'd0);
    checkOutput("fp32_sticky", 55'(s), 55'd0);

    applyStimulus(2'd0, ONE, ONE_HALF, 0, 0, q, s, lat);
    checkOutput("fp16_latency", 55'(lat), 55'd14);
    checkOutput("fp16_quo", q, 55'h2AA80000000000);
    checkOutput("fp16_sticky", 55'(s), 55'd1);

    applyStimulus(2'd1, randSig(2'd1), randSig(2'd1), 0, 10, q, s, lat);
    @(negedge clk);
    checkOutput("bp_idle_after", 55'(divIf.start_ready_o), 55'd1);
    @(posedge clk); #1;

    startOp(2'd2, randSig(2'd2), ONE_HALF, 0);
    repeat (19) begin @(posedge clk); #1; end
    divIf.flush_i = 1'b1;
    @(negedge clk);
    checkOutput("flush_ready_low", 55'(divIf.start_ready_o), 55'd0);
    @(posedge clk); #1;
    divIf.flush_i = 1'b0;
    applyStimulus(2'd0, ONE, ONE, 0, 0, q, s, lat);
    checkOutput("post_flush_latency", 55'(lat), 55'd14);
    checkOutput("post_flush_quo", q, 55'h40000000000000);

    // A start offered together with flush must be refused.
    divIf.fp_format_i   = 2'd0;
    divIf.siga_i        = ONE;
    divIf.sigb_i        = ONE;
    divIf.start_valid_i = 1'b1;
    divIf.flush_i       = 1'b1;
    @(posedge clk); #1;
    divIf.start_valid_i = 1'b0;
    divIf.flush_i       = 1'b0;
    @(negedge clk);
    checkOutput("flush_blocks_start", 55'(divIf.start_ready_o), 55'd1);
    @(posedge clk); #1;

    startOp(2'd1, randSig(2'd1), randSig(2'd1), 0);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_valid", 55'(divIf.finish_valid_o), 55'd0);
    checkOutput("midreset_quo", divIf.quo_o, 55'd0);
    checkOutput("midreset_sticky", 55'(divIf.sticky_o), 55'd0);
    checkOutput("midreset_ready", 55'(divIf.start_ready_o), 55'd1);
    @(posedge clk); #1;

    applyStimulus(2'd1, randSig(2'd1), 53'h08000000000000, 0, 0, q, s, lat);
    checkOutput("unnormalized_latency", 55'(lat), 55'd27);

    for (int i = 0; i < 40; i++) begin
      fmt = 2'($urandom_range(0, 3));
      a   = randSig(fmt);
      b   = randSig(fmt);
      if ($urandom_range(0, 3) == 0) a = b;
      applyStimulus(fmt, a, b, $urandom_range(0, 7), $urandom_range(0, 7), q, s, lat);
      checkOutput("rand_latency", 55'(lat), 55'(nIter(fmt) + 1));
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
